snax_tcdm_responder: RTL and testbench
======================================

// Module: snax_tcdm_responder
// PURPOSE
//  Subordinate end of the SNAX TCDM request/response interface: multi-port, word-interleaved banked SRAM model.
//  Accepts tcdm_req_t from streamer/accelerator initiators and returns q_ready / p_valid / p.data.
//  Used as the memory side in stand-alone streamer+accelerator benches in place of the cluster TCDM interconnect.
// PARAMETERS
//  NumPorts    4    number of initiator TCDM ports
//  DataWidth   64   word width in bits (multiple of 8)
//  AddrWidth   48   byte-address width of q.addr
//  NumBanks    8    power of two; word-interleaved banks
//  BankWords   256  power of two; words per bank
//  CntWidth    32   width of the conflict counter
//  tcdm_req_t  logic  request type: q{addr,write,amo,data,strb,user}, q_valid
//  tcdm_rsp_t  logic  response type: q_ready, p_valid, p{data}
// PORTS
//  clk_i         in   1                 clock, all logic on rising edge
//  rst_i         in   1                 asynchronous, active-high reset
//  tcdm_req_i    in   NumPorts x req_t  requests from initiators
//  tcdm_rsp_o    out  NumPorts x rsp_t  responses to initiators
//  conflict_cnt_o out CntWidth          total requests denied by bank conflict since reset
// BEHAVIOUR
//  Address map: word = addr >> log2(DataWidth/8); bank = word % NumBanks; row = (word / NumBanks) % BankWords.
//   Upper address bits ignored (aliasing wraps silently); low byte-offset bits ignored.
//  Arbitration: per bank, round-robin among ports with q_valid mapping to that bank; at most one grant per bank/cycle.
//   RR pointer per bank starts at port 0, moves to (granted port + 1) % NumPorts after each grant; unchanged when idle.
//  q_ready is combinational, same cycle as q_valid; handshake = q_valid & q_ready. Ungranted ports get q_ready=0 and
//   must hold the request stable (checked by assertion in simulation).
//  Write: on handshake, bytes with strb[b]=1 updated at row; visible to reads granted in the next cycle or later. No p_valid.
//  Read: on handshake, p_valid=1 and p.data=row contents exactly 1 cycle later; no p_ready, response cannot stall.
//   Back-to-back reads on one port yield back-to-back p_valid.
//  amo ignored (treated as plain read/write); user field ignored.
//  Conflict counter: += number of ports with q_valid & !q_ready each cycle; saturates at all-ones, no wrap.
//  Simultaneous read and write to same bank: only one granted (RR order); the other retries.
//  Reset: all p_valid=0, p.data=0, RR pointers=0, conflict_cnt_o=0; pending read responses discarded.
//   Mid-operation reset: response due the next cycle is dropped. SRAM contents are NOT reset (X in sim until written).
//  q_ready is 0 for all ports while rst_i is high.
// CONFIGURATION
//  SNAX_TCDM_RESP_STALL_EN defined: a 16-bit LFSR per port (seed 16'hACE1 ^ port index, polynomial x^16+x^14+x^13+x^11+1),
//   advanced every cycle; when its LSB is 1 the port is masked from arbitration (q_ready=0, not counted as conflict).
//   Deterministic and reset to seed by rst_i. Exercises initiator backpressure.
//  Not defined: no masking; a request to a bank with no competitor is always granted in the same cycle.
// STRUCTURE
//  Package snax_tcdm_responder_pkg: functions addr_to_bank/addr_to_row, LFSR seed/taps constants.
//  Sub-module snax_tcdm_bank_arbiter: one instance per bank; NumPorts-wide req vector in, one-hot grant out,
//   owns its RR pointer. Top holds bank SRAM arrays, port->bank decode, 1-deep read-response register per port.
// TESTING
//  1 Port0 write addr 0x08 data 0x1122334455667788 strb 0xFF, next cycle read 0x08 -> p_valid 1 cycle later, data 0x1122334455667788.
//  2 Write 0x10 all-ones, then write strb 0x0F data 0 -> read returns 0xFFFFFFFF00000000.
//  3 Ports 0-3 all read bank 0 (addrs 0x00,0x40,0x80,0xC0) every cycle -> grants in order 0,1,2,3, one per cycle; conflict_cnt_o=3+2+1=6.
//  4 Ports 0-3 read banks 0-3 concurrently -> all q_ready=1 same cycle, four p_valid next cycle, conflict_cnt_o unchanged.
//  5 Read granted, rst_i pulsed next edge -> no p_valid after reset, pointers/counter 0; prior written data still readable.
//  6 With SNAX_TCDM_RESP_STALL_EN: 1000 random requests on 4 ports -> all eventually granted, scoreboard data match, no drops.

Source files
------------

// File: rtl/snax_tcdm_responder_pkg.sv
// Shared types, sizing constants and address-decode helpers for the SNAX TCDM responder.
// SNAX_TCDM_RESP_STALL_EN enables per-port pseudo-random backpressure in snax_tcdm_responder.
package snax_tcdm_responder_pkg;

  localparam int unsigned NumPorts  = 4;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned AddrWidth = 48;
  localparam int unsigned NumBanks  = 8;
  localparam int unsigned BankWords = 256;
  localparam int unsigned CntWidth  = 32;

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned AmoWidth  = 4;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned ByteOffW  = $clog2(StrbWidth);
  localparam int unsigned BankIdxW  = $clog2(NumBanks);
  localparam int unsigned RowIdxW   = $clog2(BankWords);
  localparam int unsigned PortIdxW  = $clog2(NumPorts);

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the LSB
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'h002D;

  typedef logic [BankIdxW-1:0] bank_idx_t;
  typedef logic [RowIdxW-1:0]  row_idx_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [AmoWidth-1:0]  amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

  function automatic bank_idx_t addr_to_bank(input logic [AddrWidth-1:0] addr);
    return addr[ByteOffW +: BankIdxW];
  endfunction

  function automatic row_idx_t addr_to_row(input logic [AddrWidth-1:0] addr);
    return addr[ByteOffW + BankIdxW +: RowIdxW];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LfsrTaps), state[15:1]};
  endfunction

endpackage

// File: rtl/snax_tcdm_bank_arbiter.sv
// Round-robin arbiter for one SRAM bank: grants at most one requesting port per cycle.
// The priority pointer moves past the winner after every grant and holds while idle.
module snax_tcdm_bank_arbiter
  import snax_tcdm_responder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NumPorts-1:0] req,
  output logic [NumPorts-1:0] gnt
);

  logic [PortIdxW-1:0] ptr_q, ptr_d;
  logic [PortIdxW-1:0] idx;
  logic                found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NumPorts; k++) begin
      idx = PortIdxW'((int'(ptr_q) + k) % NumPorts);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PortIdxW'((int'(idx) + 1) % NumPorts);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/snax_tcdm_responder.sv
// Multi-port word-interleaved banked SRAM model answering SNAX TCDM requests.
// Define SNAX_TCDM_RESP_STALL_EN to mask ports from arbitration with a per-port LFSR.
module snax_tcdm_responder
  import snax_tcdm_responder_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  tcdm_req_t           tcdm_req_i     [NumPorts],
  output tcdm_rsp_t           tcdm_rsp_o     [NumPorts],
  output logic [CntWidth-1:0] conflict_cnt_o
);

  localparam int unsigned CountW = PortIdxW + 1;

  bank_idx_t           port_bank [NumPorts];
  row_idx_t            port_row  [NumPorts];
  logic [NumPorts-1:0] port_stall, port_req, port_gnt, port_rd;

  logic [NumPorts-1:0] bank_req [NumBanks];
  logic [NumPorts-1:0] bank_gnt [NumBanks];

  logic [NumBanks-1:0]  bank_we;
  row_idx_t             bank_wrow  [NumBanks];
  logic [DataWidth-1:0] bank_wdata [NumBanks];
  logic [StrbWidth-1:0] bank_wstrb [NumBanks];

  logic [DataWidth-1:0] mem_q [NumBanks][BankWords];

  logic [NumPorts-1:0]  rsp_valid_q;
  logic [DataWidth-1:0] rsp_data_q [NumPorts];

  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth:0]    cnt_sum;
  logic [CountW-1:0]    conflict_num;
  logic                 unused_req_bits;

`ifdef SNAX_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q [NumPorts];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) lfsr_q[p] <= LfsrSeed ^ 16'(p);
    end else begin
      for (int p = 0; p < NumPorts; p++) lfsr_q[p] <= lfsr_next(lfsr_q[p]);
    end
  end

  always_comb begin
    port_stall = '0;
    for (int p = 0; p < NumPorts; p++) port_stall[p] = lfsr_q[p][0];
  end
`else
  assign port_stall = '0;
`endif

  // Port decode; stalled ports and reset are hidden from arbitration entirely
  always_comb begin
    port_req        = '0;
    port_rd         = '0;
    unused_req_bits = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      port_bank[p] = addr_to_bank(tcdm_req_i[p].q.addr);
      port_row[p]  = addr_to_row(tcdm_req_i[p].q.addr);
      port_req[p]  = tcdm_req_i[p].q_valid & ~port_stall[p] & ~rst_i;
      port_rd[p]   = port_gnt[p] & ~tcdm_req_i[p].q.write;
      unused_req_bits = unused_req_bits ^ (^tcdm_req_i[p].q.amo) ^ (^tcdm_req_i[p].q.user);
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      bank_req[b] = '0;
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = port_req[p] && (port_bank[p] == BankIdxW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank_arb
    snax_tcdm_bank_arbiter u_arb (
      .clk (clk_i),
      .rst (rst_i),
      .req (bank_req[b]),
      .gnt (bank_gnt[b])
    );
  end

  always_comb begin
    port_gnt = '0;
    for (int b = 0; b < NumBanks; b++) port_gnt = port_gnt | bank_gnt[b];
  end

  // Per-bank write port, driven by whichever port won the bank this cycle
  always_comb begin
    bank_we = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_wrow[b]  = '0;
      bank_wdata[b] = '0;
      bank_wstrb[b] = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[b][p] && tcdm_req_i[p].q.write) begin
          bank_we[b]    = 1'b1;
          bank_wrow[b]  = port_row[p];
          bank_wdata[b] = tcdm_req_i[p].q.data;
          bank_wstrb[b] = tcdm_req_i[p].q.strb;
        end
      end
    end
  end

  // SRAM contents deliberately have no reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_we[b]) begin
        for (int i = 0; i < StrbWidth; i++) begin
          if (bank_wstrb[b][i]) mem_q[b][bank_wrow[b]][8*i +: 8] <= bank_wdata[b][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      for (int p = 0; p < NumPorts; p++) rsp_data_q[p] <= '0;
    end else begin
      rsp_valid_q <= port_rd;
      for (int p = 0; p < NumPorts; p++) begin
        if (port_rd[p]) rsp_data_q[p] <= mem_q[port_bank[p]][port_row[p]];
      end
    end
  end

  always_comb begin
    conflict_num = '0;
    for (int p = 0; p < NumPorts; p++) begin
      conflict_num = conflict_num + CountW'(port_req[p] & ~port_gnt[p]);
    end
    cnt_sum = {1'b0, cnt_q} + (CntWidth + 1)'(conflict_num);
    cnt_d   = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      tcdm_rsp_o[p].q_ready = port_gnt[p];
      tcdm_rsp_o[p].p_valid = rsp_valid_q[p];
      tcdm_rsp_o[p].p.data  = rsp_data_q[p];
    end
  end

  assign conflict_cnt_o = cnt_q;

  // Initiators must keep a refused request unchanged until it is accepted
  for (genvar p = 0; p < NumPorts; p++) begin : g_hold_chk
    hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (tcdm_req_i[p].q_valid && !tcdm_rsp_o[p].q_ready)
        |=> (tcdm_req_i[p].q_valid && $stable(tcdm_req_i[p].q)));
  end

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Self-checking bench for snax_tcdm_responder: directed cases plus randomized traffic
// checked against a word-addressed memory model with per-bank round-robin rules.
module tb_snax_tcdm_responder;
  import snax_tcdm_responder_pkg::*;

  localparam int unsigned Words = NumBanks * BankWords;

  logic                clk = 1'b0;
  logic                rst;
  tcdm_req_t           req_drv [NumPorts];
  tcdm_rsp_t           rsp     [NumPorts];
  logic [CntWidth-1:0] cnt;

  snax_tcdm_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm_req_i     (req_drv),
    .tcdm_rsp_o     (rsp),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0]     mmem [Words];
  int              mptr [NumBanks];
  longint unsigned mcnt;
  bit              mpv  [NumPorts];
  logic [63:0]     mpd  [NumPorts];
  bit [15:0]       mlfsr[NumPorts];

  tcdm_req_chan_t  pq   [NumPorts][$];
  logic [63:0]     rlog [NumPorts][$];
  int              glog[$];
  int              gcyc[$];
  int              cyc = 0;
  logic [NumPorts-1:0] last_rdy, last_pv;
  int              reads_issued = 0;
  int              reads_seen = 0;

  function automatic int word_of(input logic [AddrWidth-1:0] a);
    return int'((a >> 3) % Words);
  endfunction

  function automatic int bank_of(input logic [AddrWidth-1:0] a);
    return word_of(a) % NumBanks;
  endfunction

  function automatic bit busy();
    for (int p = 0; p < NumPorts; p++) if (pq[p].size() != 0 || mpv[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NumBanks; b++) mptr[b] = 0;
    mcnt = 0;
    for (int p = 0; p < NumPorts; p++) begin
      mpv[p]   = 1'b0;
      mpd[p]   = '0;
      mlfsr[p] = 16'hACE1 ^ 16'(p);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NumPorts; p++) begin
      if (pq[p].size() != 0) begin
        req_drv[p].q       = pq[p][0];
        req_drv[p].q_valid = 1'b1;
      end else begin
        req_drv[p] = '0;
      end
    end
  endtask

  task automatic push(input int p, input logic [47:0] a, input bit wr, input logic [63:0] d,
                      input logic [7:0] s);
    tcdm_req_chan_t r;
    r.addr  = a;
    r.write = wr;
    r.amo   = 4'($urandom);
    r.data  = d;
    r.strb  = s;
    r.user  = 1'($urandom);
    pq[p].push_back(r);
  endtask

  // One clock: drive after the falling edge, check, then advance the model across the next rise
  task automatic cycle();
    bit [NumPorts-1:0] valid, stall, exp_rdy;
    int pb [NumPorts];
    int owner [NumBanks];
    int nconf, p, w;
    @(negedge clk);
    drive();
    #1;
    cyc++;
    for (int i = 0; i < NumPorts; i++) begin
      valid[i] = pq[i].size() != 0;
      pb[i]    = valid[i] ? bank_of(pq[i][0].addr) : -1;
`ifdef SNAX_TCDM_RESP_STALL_EN
      stall[i] = mlfsr[i][0];
`else
      stall[i] = 1'b0;
`endif
    end
    exp_rdy = '0;
    for (int b = 0; b < NumBanks; b++) begin
      owner[b] = -1;
      for (int k = 0; k < NumPorts; k++) begin
        p = (mptr[b] + k) % NumPorts;
        if (owner[b] < 0 && valid[p] && !stall[p] && pb[p] == b) begin
          owner[b]   = p;
          exp_rdy[p] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NumPorts; i++) begin
      check_eq($sformatf("q_ready[%0d]", i), rsp[i].q_ready, exp_rdy[i]);
      check_eq($sformatf("p_valid[%0d]", i), rsp[i].p_valid, mpv[i]);
      if (mpv[i]) check_eq($sformatf("p_data[%0d]", i), rsp[i].p.data, mpd[i]);
      if (rsp[i].p_valid) begin
        rlog[i].push_back(rsp[i].p.data);
        reads_seen++;
      end
      if (rsp[i].q_ready) begin
        glog.push_back(i);
        gcyc.push_back(cyc);
      end
      last_rdy[i] = rsp[i].q_ready;
      last_pv[i]  = rsp[i].p_valid;
    end
    check_eq("conflict_cnt", cnt, mcnt);
    nconf = 0;
    for (int i = 0; i < NumPorts; i++) if (valid[i] && !stall[i] && !exp_rdy[i]) nconf++;
    mcnt = mcnt + longint'(nconf);
    if (mcnt > 64'hFFFF_FFFF) mcnt = 64'hFFFF_FFFF;
    for (int i = 0; i < NumPorts; i++) begin
      mpv[i] = 1'b0;
      if (exp_rdy[i]) begin
        w = word_of(pq[i][0].addr);
        if (!pq[i][0].write) begin
          mpv[i] = 1'b1;
          mpd[i] = mmem[w];
          reads_issued++;
        end else begin
          for (int j = 0; j < 8; j++)
            if (pq[i][0].strb[j]) mmem[w][8*j +: 8] = pq[i][0].data[8*j +: 8];
        end
        void'(pq[i].pop_front());
      end
    end
    for (int b = 0; b < NumBanks; b++) if (owner[b] >= 0) mptr[b] = (owner[b] + 1) % NumPorts;
    for (int i = 0; i < NumPorts; i++)
      mlfsr[i] = {mlfsr[i][0] ^ mlfsr[i][2] ^ mlfsr[i][3] ^ mlfsr[i][5], mlfsr[i][15:1]};
  endtask

  // Let the pending rising edge consume the last driven requests, then idle the inputs
  task automatic settle();
    @(posedge clk);
    #1;
    for (int p = 0; p < NumPorts; p++) req_drv[p] = '0;
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_done", 64'(busy()), 64'd0);
    settle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int p = 0; p < NumPorts; p++) req_drv[p] = '0;
    model_reset();
    @(negedge clk);
    #1;
    for (int p = 0; p < NumPorts; p++) begin
      check_eq($sformatf("rst_q_ready[%0d]", p), rsp[p].q_ready, 1'b0);
      check_eq($sformatf("rst_p_valid[%0d]", p), rsp[p].p_valid, 1'b0);
      check_eq($sformatf("rst_p_data[%0d]", p), rsp[p].p.data, 64'd0);
    end
    check_eq("rst_cnt", cnt, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [47:0] a;
    rst = 1'b1;
    for (int p = 0; p < NumPorts; p++) req_drv[p] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Preload words 0..63 so every later read targets known contents
    for (int w = 0; w < 64; w++) push(w % NumPorts, 48'(w) << 3, 1'b1, {$urandom, $urandom}, 8'hFF);
    run_drain(500);

    // Write then read back on port 0
    push(0, 48'h08, 1'b1, 64'h1122334455667788, 8'hFF);
    push(0, 48'h08, 1'b0, 64'd0, 8'h00);
    run_drain(200);
    check_eq("t1_rdata", rlog[0].size() != 0 ? rlog[0][$] : 64'd0, 64'h1122334455667788);

    // Partial-strobe overwrite
    push(0, 48'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    push(0, 48'h10, 1'b1, 64'd0, 8'h0F);
    push(0, 48'h10, 1'b0, 64'd0, 8'h00);
    run_drain(200);
    check_eq("t2_rdata", rlog[0].size() != 0 ? rlog[0][$] : 64'd0, 64'hFFFF_FFFF_0000_0000);

    // Reset right after a read is accepted: its response must vanish
    push(0, 48'h08, 1'b0, 64'd0, 8'h00);
    n = 0;
    while (pq[0].size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check_eq("t5_granted", 64'(pq[0].size()), 64'd0);
    do_reset();
    cycle();
    check_eq("t5_no_pvalid", 64'(last_pv), 64'd0);
    push(1, 48'h08, 1'b0, 64'd0, 8'h00);
    run_drain(200);
    check_eq("t5_kept_data", rlog[1].size() != 0 ? rlog[1][$] : 64'd0, 64'h1122334455667788);

    // Four ports contending for bank 0
    glog.delete();
    gcyc.delete();
    for (int p = 0; p < NumPorts; p++) push(p, 48'(p) << 6, 1'b0, 64'd0, 8'h00);
    run_drain(200);
`ifndef SNAX_TCDM_RESP_STALL_EN
    check_eq("t3_ngrants", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_order[%0d]", i), glog.size() > i ? glog[i] : -1, i);
      check_eq($sformatf("t3_cycle[%0d]", i), gcyc.size() > i ? gcyc[i] - gcyc[0] : -1, i);
    end
    check_eq("t3_cnt", cnt, 64'd6);
`endif

    // Four ports on four different banks
    for (int p = 0; p < NumPorts; p++) push(p, 48'(p) << 3, 1'b0, 64'd0, 8'h00);
    cycle();
    cycle();
`ifndef SNAX_TCDM_RESP_STALL_EN
    check_eq("t4_all_ready", 64'(last_rdy), 64'd0);
    check_eq("t4_all_pvalid", 64'(last_pv), 64'hF);
`endif
    run_drain(200);
`ifndef SNAX_TCDM_RESP_STALL_EN
    check_eq("t4_cnt", cnt, 64'd6);
`endif

    // Random traffic over words 0..63 with aliased upper address bits
    reads_issued = 0;
    reads_seen   = 0;
    for (int i = 0; i < 1000; i++) begin
      a = (48'($urandom_range(0, 255)) << 14) | (48'($urandom_range(0, 63)) << 3)
        | 48'($urandom_range(0, 7));
      push($urandom_range(0, NumPorts - 1), a, 1'($urandom), {$urandom, $urandom}, 8'($urandom));
    end
    run_drain(30000);
    check_eq("rand_reads", 64'(reads_seen), 64'(reads_issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
